// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO controllers: Gray/binary conversion and pointer width.
package async_fifo_pkg;

  localparam int MAX_W = 32;

  function automatic int PTR_W(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray input decodes correctly since upper zeros do not alter the prefix XOR.
  function automatic logic [MAX_W-1:0] gray2bin_f(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-client / memory-side bundle of the async FIFO write controller.
interface async_fifo_wr_ctrl_if #(parameter int ADDR_WIDTH = 4);
  localparam int PW = ADDR_WIDTH + 1;

  logic                  wr_en;
  logic                  wr_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [PW-1:0]         wptr_gray;
  logic [PW-1:0]         rptr_gray_async;
  logic [PW-1:0]         wr_count;
  logic                  almost_full;
  logic                  overflow;
  logic                  overflow_clr;

  modport master (
    output wr_en, rptr_gray_async, overflow_clr,
    input  wr_ready, mem_we, mem_waddr, wptr_gray, wr_count, almost_full, overflow
  );

  modport slave (
    input  wr_en, rptr_gray_async, overflow_clr,
    output wr_ready, mem_we, mem_waddr, wptr_gray, wr_count, almost_full, overflow
  );
endinterface

// File: rtl/async_fifo_wr_ctrl_sync.sv
// N-stage flop synchroniser for a Gray-coded pointer crossing clock domains.
module gray_sync #(
  parameter int SIZE   = 5,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);
  logic [STAGES-1:0][SIZE-1:0] chain;

  // Input lands directly on the first flop; nothing combinational in front of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer/flag controller: owns the Gray write pointer, syncs the read pointer,
// and derives full, almost_full, fill level and a sticky overflow flag.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input logic                 clk,
  input logic                 rst,
  async_fifo_wr_ctrl_if.slave bus
);
  localparam int PW = PTR_W(ADDR_WIDTH);
  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW-2);

  logic [PW-1:0] wbin, wbin_next, wgray, wgray_next;
  logic [PW-1:0] rq, rbin, fill_next, count_q;
  logic          full, rdy_q, accept, afull_q, ovf_q;

  gray_sync #(.SIZE(PW), .STAGES(SYNC_STAGES)) u_rsync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rptr_gray_async),
    .q   (rq)
  );

  // rdy_q holds wr_ready low until the first edge after reset is released.
  assign bus.wr_ready  = rdy_q & ~full;
  assign accept        = bus.wr_en & bus.wr_ready;
  assign bus.mem_we    = accept;
  assign bus.mem_waddr = wbin[ADDR_WIDTH-1:0];
  assign bus.wptr_gray = wgray;
  assign bus.wr_count  = count_q;
  assign bus.almost_full = afull_q;
  assign bus.overflow  = ovf_q;

  assign wbin_next  = wbin + PW'(accept);
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));
  assign rbin       = PW'(gray2bin_f(32'(rq)));
  assign fill_next  = wbin_next - rbin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      wbin    <= '0;
      wgray   <= '0;
      full    <= 1'b0;
      count_q <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      full    <= (wgray_next == (rq ^ FULL_MASK));
      count_q <= fill_next;
      afull_q <= (fill_next >= PW'(AFULL_THRESH));
      if (bus.wr_en & full)      ovf_q <= 1'b1;
      else if (bus.overflow_clr) ovf_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2, AFULL_THRESH=12).
module tb_async_fifo_wr_ctrl;
  logic clk, rst;
  int   tests = 0;
  int   fails = 0;

  async_fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

  async_fifo_wr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .AFULL_THRESH(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [4:0] w, r, prevg;
    int nr;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.overflow_clr = 1'b0;
    bus.rptr_gray_async = '0;
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_ready", 32'(bus.wr_ready), 0);
    chk("rst_gray", 32'(bus.wptr_gray), 0);
    chk("rst_count", 32'(bus.wr_count), 0);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_waddr", 32'(bus.mem_waddr), 0);
    #2 rst = 1'b0;
    #1 chk("rel_ready_low", 32'(bus.wr_ready), 0);
    tick();
    chk("rel_ready_high", 32'(bus.wr_ready), 1);

    // Fill all 16 entries back-to-back with the read pointer parked at 0.
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1;
      #1;
      chk("fill_waddr", 32'(bus.mem_waddr), 32'(i));
      chk("fill_we", 32'(bus.mem_we), 1);
      tick();
      chk("fill_count", 32'(bus.wr_count), 32'(i+1));
      chk("fill_afull", 32'(bus.almost_full), 32'(i+1 >= 12));
      chk("fill_ready", 32'(bus.wr_ready), 32'(i+1 < 16));
      chk("fill_gray", 32'(bus.wptr_gray), 32'(g(5'(i+1))));
    end
    bus.wr_en = 1'b0;

    // Write attempt while full.
    bus.wr_en = 1'b1;
    #1 chk("ovf_we", 32'(bus.mem_we), 0);
    tick();
    bus.wr_en = 1'b0;
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_gray", 32'(bus.wptr_gray), 32'h18);
    chk("ovf_count", 32'(bus.wr_count), 16);
    tick();
    chk("ovf_sticky", 32'(bus.overflow), 1);
    bus.overflow_clr = 1'b1;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    chk("ovf_set_wins", 32'(bus.overflow), 1);
    tick();
    chk("ovf_clr", 32'(bus.overflow), 0);
    bus.overflow_clr = 1'b0;

    // One read release: visible after SYNC_STAGES+1 edges.
    bus.rptr_gray_async = 5'd1;
    tick();
    chk("rel_e1_ready", 32'(bus.wr_ready), 0);
    tick();
    chk("rel_e2_ready", 32'(bus.wr_ready), 0);
    chk("rel_e2_count", 32'(bus.wr_count), 16);
    tick();
    chk("rel_e3_ready", 32'(bus.wr_ready), 1);
    chk("rel_e3_count", 32'(bus.wr_count), 15);
    chk("rel_e3_afull", 32'(bus.almost_full), 1);

    // Write accepted on the edge that first uses a freshly synchronised read release.
    bus.rptr_gray_async = g(5'd2);
    tick();
    tick();
    chk("sim_pre_count", 32'(bus.wr_count), 15);
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    chk("sim_count", 32'(bus.wr_count), 15);
    chk("sim_ovf", 32'(bus.overflow), 0);
    chk("sim_ready", 32'(bus.wr_ready), 1);
    chk("sim_gray", 32'(bus.wptr_gray), 32'(g(5'd17)));

    // 40 writes interleaved with read advances across pointer/address wraps.
    w = 5'd17;
    r = 5'd2;
    for (int i = 0; i < 40; i++) begin
      prevg = bus.wptr_gray;
      chk("wrap_waddr", 32'(bus.mem_waddr), 32'(w[3:0]));
      chk("wrap_ready", 32'(bus.wr_ready), 1);
      bus.wr_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      w = w + 5'd1;
      chk("wrap_onebit", $countones(bus.wptr_gray ^ prevg), 1);
      chk("wrap_gray", 32'(bus.wptr_gray), 32'(g(w)));
      nr = ((i % 3) == 0 && 5'(w - r) >= 5'd2) ? 2 : 1;
      for (int j = 0; j < nr; j++) begin
        r = r + 5'd1;
        bus.rptr_gray_async = g(r);
        tick();
      end
      tick(); tick(); tick();
      chk("wrap_count", 32'(bus.wr_count), 32'(5'(w - r)));
    end

    // Asynchronous reset between edges during a burst.
    bus.wr_en = 1'b1;
    tick();
    #2 rst = 1'b1;
    bus.rptr_gray_async = '0;
    #1;
    chk("arst_ready", 32'(bus.wr_ready), 0);
    chk("arst_we", 32'(bus.mem_we), 0);
    chk("arst_gray", 32'(bus.wptr_gray), 0);
    chk("arst_count", 32'(bus.wr_count), 0);
    chk("arst_waddr", 32'(bus.mem_waddr), 0);
    chk("arst_afull", 32'(bus.almost_full), 0);
    chk("arst_ovf", 32'(bus.overflow), 0);
    tick();
    #2 rst = 1'b0;
    #1 chk("arel_ready_low", 32'(bus.wr_ready), 0);
    tick();
    chk("arel_we", 32'(bus.mem_we), 1);
    chk("arel_waddr", 32'(bus.mem_waddr), 0);
    tick();
    bus.wr_en = 1'b0;
    chk("arel_gray", 32'(bus.wptr_gray), 1);
    chk("arel_count", 32'(bus.wr_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
